// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration logic.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam int RR_MAX = 8;
  localparam int RR_IW  = $clog2(RR_MAX);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } arb_state_e;

  // First set bit of valid[n-1:0] at or after ptr, wrapping; returns ptr if none set.
  function automatic int rr_pick(input logic [RR_MAX-1:0] valid, input int ptr, input int n);
    int j;
    rr_pick = ptr;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (valid[RR_IW'(j)]) rr_pick = j;
      end
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-priority encoder: lowest valid index at or after ptr.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);
  import uart_pkg::*;

  logic [RR_MAX-1:0] valid_pad;

  assign valid_pad = RR_MAX'(valid);
  assign any       = |valid;
  assign idx       = IW'(rr_pick(valid_pad, int'(ptr), N));

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked byte arbiter that feeds one UART transmitter
// through a single staging register standing in for its Tx FIFO.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = uart_pkg::DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic                      glb_clk,
  input  logic                      glb_rst,
  input  logic                      cfg_en,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         Tx_data_o,
  output logic                      FIFO_ctrl_empty_o,
  input  logic                      STM_ctrl_FIFO_r_en_i,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);
  import uart_pkg::*;

  localparam int GW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e        state, state_nxt;
  logic              stage_valid;
  logic [GW-1:0]     rr_ptr, pick_idx;
  logic              pick_any;
  logic [BW-1:0]     burst_cnt, burst_inc;
  logic              g_valid, g_last, xfer, rel, start;
  logic [DATA_W-1:0] g_data;

  rr_priority_pick #(.N(N_REQ), .IW(GW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];
  assign g_data  = req_data[grant_id*DATA_W +: DATA_W];

  // A byte may enter the stage when it is empty or being drained this cycle.
  assign xfer  = (state == S_GRANT) && g_valid && (!stage_valid || STM_ctrl_FIFO_r_en_i);
  assign start = (state == S_IDLE) && cfg_en && pick_any;

  assign burst_inc = (burst_cnt == BW'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;

  // Idle requester releases only once its last byte has left the stage.
  assign rel = (state == S_GRANT) &&
               ((xfer && (g_last || (burst_inc == BW'(MAX_BURST)))) ||
                (!g_valid && !stage_valid));

  assign FIFO_ctrl_empty_o = !stage_valid;
  assign busy              = (state != S_IDLE) || stage_valid;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_GRANT;
      end
      S_GRANT: begin
        req_ready[grant_id] = xfer;
        if (rel) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      stage_valid <= 1'b0;
      Tx_data_o   <= '0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
    end else begin
      if (start) begin
        grant_id  <= pick_idx;
        burst_cnt <= '0;
      end
      if (xfer) burst_cnt <= burst_inc;
      if (rel)  rr_ptr <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
      // Simultaneous consume and accept replaces the byte without a bubble.
      if (xfer) begin
        Tx_data_o   <= g_data;
        stage_valid <= 1'b1;
      end else if (STM_ctrl_FIFO_r_en_i) begin
        stage_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART_Tx_module between N_REQ byte requesters.
- Each requester streams bytes over a valid/ready handshake. The arbiter stages one byte and presents it to the transmitter through the transmitter's existing FIFO-style interface (data, FIFO_ctrl_empty, STM_ctrl_FIFO_r_en).
- It sits in place of the Tx FIFO in front of UART_Tx_module.
- Grants are message-locked: a grant is held until the message ends, a burst limit is reached, or the requester goes idle.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the Tx payload.
- MAX_BURST, 4, maximum bytes accepted per grant before forced rotation (1..255).

Ports:
- glb_clk  input  1  system clock, all logic on rising edge.
- glb_rst  input  1  synchronous active-high reset.
- cfg_en  input  1  arbiter enable; 0 means no new grants are issued.
- req_valid  input  N_REQ  per-requester byte valid.
- req_data  input  N_REQ*DATA_W  requester i owns bits [i*DATA_W +: DATA_W].
- req_last  input  N_REQ  marks the final byte of a message.
- req_ready  output  N_REQ  per-requester byte accepted this cycle.
- Tx_data_o  output  DATA_W  staged byte to the transmitter.
- FIFO_ctrl_empty_o  output  1  1 = no staged byte.
- STM_ctrl_FIFO_r_en_i  input  1  one-cycle pulse: the transmitter consumed Tx_data_o.
- grant_id  output  $clog2(N_REQ)  current or last grant index.
- busy  output  1  1 when state is not IDLE or a byte is staged.

Behaviour:
- Reset (synchronous, glb_rst=1 at a rising edge): state=IDLE, stage_valid=0, Tx_data_o=0, FIFO_ctrl_empty_o=1, req_ready=0, grant_id=0, rr_ptr=0, burst_cnt=0, busy=0. Reset mid-transfer discards the staged byte. A byte already latched by UART_Tx_module is not affected.
- States: IDLE, GRANT.
- IDLE:
  - If cfg_en=1 and any req_valid=1, select the first valid index at or after rr_ptr, wrapping modulo N_REQ.
  - Load grant_id with that index, clear burst_cnt, and move to GRANT on the next edge.
  - Arbitration latency is 1 cycle; req_ready is 0 in IDLE.
- GRANT:
  - req_ready[grant_id] = req_valid[grant_id] & (~stage_valid | STM_ctrl_FIFO_r_en_i). All other req_ready bits are 0. The path is combinational from valid and r_en.
  - Transfer = req_valid[g] & req_ready[g]. On a transfer: stage the byte into Tx_data_o, set stage_valid=1, burst_cnt+1.
  - Release (back to IDLE, rr_ptr = grant_id+1 mod N_REQ) on any of:
    - a transfer with req_last=1;
    - a transfer with burst_cnt reaching MAX_BURST;
    - req_valid[g]=0 while stage_valid=0 (requester idle).
  - Release occurs on the same edge as the transfer. The staged byte stays until consumed, and IDLE may re-arbitrate while a byte is staged.
- Staging register:
  - FIFO_ctrl_empty_o = ~stage_valid.
  - On STM_ctrl_FIFO_r_en_i without a simultaneous transfer, stage_valid goes to 0.
  - A simultaneous r_en and transfer replaces the byte with no bubble.
  - r_en while empty is ignored (no underflow, no state change).
  - Tx_data_o holds its value while empty.
- cfg_en=0: IDLE does not grant. In GRANT, transfers continue until the next release, after which the arbiter stays in IDLE. The staged byte always drains.
- Fairness: a continuously valid requester waits at most (N_REQ-1) grants of at most MAX_BURST bytes each.
- grant_id is stable for the whole GRANT period and retains its last value in IDLE.
- burst_cnt is $clog2(MAX_BURST+1) bits wide, saturates at MAX_BURST, and never wraps.

Decomposition:
- Shared package uart_pkg holds:
  - DATA_W default;
  - state encoding localparams (ST_IDLE=1'b0, ST_GRANT=1'b1);
  - a function rr_pick(valid, ptr) returning the first set index at or after ptr, with wrap.
- One sub-module, rr_priority_pick: combinational rotate-priority encoder (inputs valid and ptr; outputs index and any). It is reused by a future Rx dispatcher.

Test Plan:
- Single requester 0 sends 0xDE,0xDF,0xE0 with last on 0xE0, Tx consumes each with a 1-cycle r_en → FIFO_ctrl_empty_o deasserts 2 cycles after the first valid; Tx_data_o sequence is DE,DF,E0; state returns to IDLE; rr_ptr=1.
- Requesters 0..3 all valid with 6-byte messages, MAX_BURST=4 → grant order 0,1,2,3,0,1,2,3; each first grant carries exactly 4 bytes and each second grant 2 bytes; bytes within each requester stay in order.
- Staged byte with r_en and req_valid in the same cycle → new byte replaces the old one with no empty cycle; no byte is lost or duplicated (scoreboard count equals 24).
- Granted requester drops valid mid-message while the stage is empty → release in that cycle; the next valid requester gets its grant 1 cycle later.
- r_en pulsed while empty; cfg_en=0 with requester 2 valid → no state change; req_ready stays 0; FIFO_ctrl_empty_o stays 1.
- glb_rst pulsed while a byte is staged and grant_id=2 → next cycle: FIFO_ctrl_empty_o=1, req_ready=0, grant_id=0, busy=0; arbitration restarts from requester 0.
